fetch_sequencer: RTL and testbench

- Instruction fetch and PC sequencing unit that replaces hand-driven `instr` stimulus with autonomous, pipelined fetch from instruction memory.
- Feeds the ID decoder through a ready/valid interface and owns the PC.
- Resolves PL/JB/BC branch decisions against Datapath flags V/C/N/Z.
- Keeps a parametrised prefetch FIFO and discards in-flight fetches on redirect.

---
 rtl/fetch_sequencer.sv | 172 +++++++++++++++++
 tb/tb_fetch_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Autonomous instruction fetch / PC sequencer with prefetch FIFO and branch redirect.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned taken targets trap instead of being aligned.
//   state  | meaning
//   S_IDLE | one cycle after reset before fetching starts
//   S_RUN  | issuing fetches, filling FIFO, resolving branches
//   S_TRAP | misaligned target seen; fetch stopped until reset
module fetch_sequencer #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] PC_RESET   = '0,
  parameter int              FIFO_DEPTH = 4,
  parameter int              MAX_OUTST  = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            br_valid,
  input  logic            PL,
  input  logic            JB,
  input  logic [2:0]      BC,
  input  logic            V,
  input  logic            C,
  input  logic            N,
  input  logic            Z,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] PCOffset,
  output logic            misalign_err
);

  localparam int              PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW        = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]     DEPTH_C   = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]   MAXO_C    = CW'(MAX_OUTST);
  localparam logic [XLEN-1:0] WORD_STEP = XLEN'(4);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TRAP} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc, r_ret_pc;
  logic [CW-1:0]   r_outst, r_drop, r_count;
  logic [PW-1:0]   r_wr, r_rd;
  logic [31:0]     r_instr_mem [FIFO_DEPTH];
  logic [XLEN-1:0] r_pc_mem    [FIFO_DEPTH];

  logic            w_fire, w_pop, w_push, w_credit, w_cond, w_taken;
  logic            w_redirect, w_trap, w_flush;
  logic [XLEN-1:0] w_target_raw, w_target;
  logic [CW-1:0]   w_inflight;

  assign w_fire       = imem_req & imem_gnt;
  assign w_pop        = instr_valid & instr_ready;
  assign w_credit     = (({1'b0, r_count} + {1'b0, r_outst}) < DEPTH_C) && (r_outst < MAXO_C);
  assign w_taken      = br_valid & (PL | JB | w_cond);
  assign w_target_raw = br_pc + PCOffset;
  assign w_flush      = w_redirect | w_trap;
  // Requests still to come back after this cycle; all of them are stale on a flush.
  assign w_inflight   = r_outst + CW'(w_fire) - CW'(imem_rvalid);
  assign w_push       = imem_rvalid && (r_drop == '0) && (r_state == S_RUN);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_target   = w_target_raw;
  assign w_misalign = |w_target_raw[1:0];
`else
  assign w_target   = w_target_raw & ~XLEN'(3);
`endif

  always_comb begin
    w_cond = 1'b0;
    case (BC)
      3'b000:  w_cond = Z;
      3'b001:  w_cond = ~Z;
      3'b100:  w_cond = N ^ V;
      3'b101:  w_cond = ~(N ^ V);
      3'b110:  w_cond = ~C;
      3'b111:  w_cond = C;
      default: w_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    w_redirect  = 1'b0;
    w_trap      = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_RUN;
      S_RUN: begin
        imem_req = w_credit;
        if (w_taken) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (w_misalign) begin
            w_trap      = 1'b1;
            w_state_nxt = S_TRAP;
          end else begin
            w_redirect = 1'b1;
          end
`else
          w_redirect = 1'b1;
`endif
        end
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= PC_RESET;
      r_ret_pc   <= PC_RESET;
      r_outst    <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_instr_mem[i] <= '0;
        r_pc_mem[i]    <= '0;
      end
    end else begin
      r_outst <= w_inflight;
      if (w_redirect)  r_fetch_pc <= w_target;
      else if (w_fire) r_fetch_pc <= r_fetch_pc + WORD_STEP;
      if (w_flush) begin
        r_wr    <= '0;
        r_rd    <= '0;
        r_count <= '0;
        r_drop  <= w_inflight;
        if (w_redirect) r_ret_pc <= w_target;
      end else begin
        if (imem_rvalid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        if (w_push) begin
          r_instr_mem[r_wr] <= imem_rdata;
          r_pc_mem[r_wr]    <= r_ret_pc;
          r_wr              <= r_wr + PW'(1);
          r_ret_pc          <= r_ret_pc + WORD_STEP;
        end
        if (w_pop) r_rd <= r_rd + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= r_misalign | w_trap;
  end
  assign misalign_err = r_misalign;
`else
  assign misalign_err = 1'b0;
`endif

  assign imem_addr   = r_fetch_pc;
  assign instr       = r_instr_mem[r_rd];
  assign instr_pc    = r_pc_mem[r_rd];
  assign instr_valid = (r_count != '0);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory model returns word = address after a set latency.
// Covers sequencing, back-pressure, branch conditions, wrap, misalignment and async reset.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr, instr_pc;
  logic        instr_valid, instr_ready;
  logic        br_valid, PL, JB, V, C, N, Z;
  logic [2:0]  BC;
  logic [31:0] br_pc, PCOffset;
  logic        misalign_err;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int unsigned due;
    logic [31:0] a;
  } rsp_t;

  rsp_t        rq[$];
  rsp_t        r_ent;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  logic [31:0] log_pc[$];
  logic [31:0] log_ins[$];
  int unsigned log_cyc[$];

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .br_valid(br_valid), .PL(PL), .JB(JB), .BC(BC), .V(V), .C(C), .N(N), .Z(Z),
    .br_pc(br_pc), .PCOffset(PCOffset), .misalign_err(misalign_err)
  );

  // Memory responder: in-order returns, `lat` cycles after the grant edge.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        rq.delete();
        imem_rvalid = 1'b0;
      end else if (rq.size() > 0 && rq[0].due == cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = rq[0].a;
        void'(rq.pop_front());
      end else begin
        imem_rvalid = 1'b0;
      end
    end
  end

  // Grant and consumption monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (imem_req && imem_gnt) begin
          r_ent.due = cyc + lat;
          r_ent.a   = imem_addr;
          rq.push_back(r_ent);
        end
        if (instr_valid && instr_ready) begin
          log_pc.push_back(instr_pc);
          log_ins.push_back(instr);
          log_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int unsigned l);
    rst      = 1'b1;
    br_valid = 1'b0;
    step();
    step();
    lat = l;
    log_pc.delete();
    log_ins.delete();
    log_cyc.delete();
    rst = 1'b0;
  endtask

  task automatic wait_pops(input int n);
    for (int i = 0; i < 60 && log_pc.size() < n; i++) step();
    if (log_pc.size() < n) check("pop_timeout", 32'(log_pc.size()), 32'(n));
  endtask

  task automatic wait_outst2();
    for (int i = 0; i < 20; i++) begin
      if (int'(rq.size()) + int'(imem_rvalid) == 2) break;
      step();
    end
  endtask

  task automatic run_br(input string tag, input logic jb, input logic pl, input logic [2:0] bc,
                        input logic [3:0] vcnz, input logic [31:0] bpc, input logic [31:0] off,
                        input logic [31:0] exp0, input logic [31:0] exp_addr);
    int mark;
    do_reset(2);
    instr_ready = 1'b1;
    wait_outst2();
    JB = jb; PL = pl; BC = bc;
    {V, C, N, Z} = vcnz;
    br_pc = bpc; PCOffset = off;
    br_valid = 1'b1;
    step();
    br_valid = 1'b0;
    check({tag, "_addr"}, imem_addr, exp_addr);
    mark = log_pc.size();
    wait_pops(mark + 2);
    check({tag, "_pc0"}, log_pc[mark], exp0);
    check({tag, "_pc1"}, log_pc[mark+1], exp0 + 32'd4);
    check({tag, "_ins0"}, log_ins[mark], exp0);
  endtask

  initial begin
    imem_gnt = 1'b1; instr_ready = 1'b1;
    br_valid = 1'b0; PL = 1'b0; JB = 1'b0; BC = 3'b000;
    {V, C, N, Z} = 4'b0000;
    br_pc = '0; PCOffset = '0;

    // Reset values
    step();
    step();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_ipc", instr_pc, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_mis", 32'(misalign_err), 32'd0);

    // Streaming with 1-cycle memory: first word 3 cycles after release, then one per cycle
    do_reset(1);
    step();
    step();
    check("seq_early", 32'(instr_valid), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("seq_valid%0d", i), 32'(instr_valid), 32'd1);
      check($sformatf("seq_pc%0d", i), instr_pc, 32'(i * 4));
      check($sformatf("seq_ins%0d", i), instr, 32'(i * 4));
      step();
    end

    // Back-pressure: FIFO fills to 4, requests stop, then drains back-to-back
    instr_ready = 1'b0;
    do_reset(1);
    for (int i = 0; i < 12; i++) step();
    check("full_req", 32'(imem_req), 32'd0);
    check("full_valid", 32'(instr_valid), 32'd1);
    check("full_head", instr_pc, 32'h0);
    check("full_pops", 32'(log_pc.size()), 32'd0);
    instr_ready = 1'b1;
    wait_pops(5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drain_pc%0d", i), log_pc[i], 32'(i * 4));
      check($sformatf("drain_gap%0d", i), 32'(log_cyc[i] - log_cyc[0]), 32'(i));
    end

    // Branch resolution with two fetches outstanding
    run_br("beq_t",  1'b0, 1'b0, 3'b000, 4'b0001, 32'h8, 32'h20, 32'h28, 32'h28);
    run_br("beq_nt", 1'b0, 1'b0, 3'b000, 4'b0000, 32'h8, 32'h20, 32'h0, 32'h8);
    run_br("blt_nt", 1'b0, 1'b0, 3'b100, 4'b1010, 32'h8, 32'h20, 32'h0, 32'h8);
    run_br("blt_t",  1'b0, 1'b0, 3'b100, 4'b0010, 32'h8, 32'h20, 32'h28, 32'h28);
    run_br("bgeu_t", 1'b0, 1'b0, 3'b111, 4'b0100, 32'h8, 32'h40, 32'h48, 32'h48);
    run_br("bltu_nt",1'b0, 1'b0, 3'b110, 4'b0100, 32'h8, 32'h40, 32'h0, 32'h8);
    run_br("bc010",  1'b0, 1'b0, 3'b010, 4'b1111, 32'h8, 32'h20, 32'h0, 32'h8);
    run_br("pl",     1'b0, 1'b1, 3'b010, 4'b0000, 32'h10, 32'h30, 32'h40, 32'h40);
    run_br("wrap",   1'b1, 1'b0, 3'b010, 4'b0000, 32'h4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'hFFFF_FFFC);

`ifdef FETCH_MISALIGN_TRAP_EN
    do_reset(2);
    instr_ready = 1'b1;
    wait_outst2();
    JB = 1'b1; PL = 1'b0; BC = 3'b010;
    br_pc = 32'h2; PCOffset = 32'h20;
    br_valid = 1'b1;
    step();
    br_valid = 1'b0;
    check("trap_mis", 32'(misalign_err), 32'd1);
    check("trap_req", 32'(imem_req), 32'd0);
    check("trap_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("trap_mis_sticky", 32'(misalign_err), 32'd1);
    check("trap_req_hold", 32'(imem_req), 32'd0);
    check("trap_valid_hold", 32'(instr_valid), 32'd0);
    check("trap_pops", 32'(log_pc.size()), 32'd0);
`else
    run_br("misal",  1'b1, 1'b0, 3'b010, 4'b0000, 32'h2, 32'h20, 32'h20, 32'h20);
    check("misal_flag", 32'(misalign_err), 32'd0);
`endif

    // Asynchronous reset mid-operation
    rst = 1'b1;
    #1;
    check("arst_req", 32'(imem_req), 32'd0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_instr", instr, 32'h0);
    check("arst_ipc", instr_pc, 32'h0);
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_mis", 32'(misalign_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
